// File: rtl/mul_tag_tracker.sv
// mul_tag_tracker: forwards operand pairs to a variable-latency multiplier,
// holds each request's destination tag in an in-order FIFO and rejoins it
// with the returning product in a one-entry registered output stage.
module mul_tag_tracker #(
  parameter int p_tag_nbits = 5,
  parameter int p_depth     = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic [63:0]               req_msg,
  input  logic [p_tag_nbits-1:0]    req_tag,
  output logic                      mul_req_val,
  input  logic                      mul_req_rdy,
  output logic [63:0]               mul_req_msg,
  input  logic                      mul_resp_val,
  output logic                      mul_resp_rdy,
  input  logic [31:0]               mul_resp_msg,
  output logic                      resp_val,
  input  logic                      resp_rdy,
  output logic [31:0]               resp_msg,
  output logic [p_tag_nbits-1:0]    resp_tag,
  output logic [$clog2(p_depth):0]  pending,
  output logic                      err
);

  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam int c_cnt_nbits = c_ptr_nbits + 1;
  localparam logic [c_ptr_nbits-1:0] c_ptr_one = 1;
  localparam logic [c_cnt_nbits-1:0] c_cnt_one = 1;
  localparam logic [c_cnt_nbits-1:0] c_cnt_full = c_cnt_nbits'(p_depth);
  localparam logic [c_cnt_nbits-1:0] c_cnt_zero = '0;

  logic [p_tag_nbits-1:0] r_tags [p_depth];
  logic [c_ptr_nbits-1:0] r_wr_ptr;
  logic [c_ptr_nbits-1:0] r_rd_ptr;
  logic [c_cnt_nbits-1:0] r_pending;
  logic                   r_err;
  logic                   r_resp_val;
  logic [31:0]            r_resp_msg;
  logic [p_tag_nbits-1:0] r_resp_tag;

  logic w_full;
  logic w_req_fire;
  logic w_mul_fire;
  logic w_pop;
  logic w_spurious;
  logic w_resp_fire;

  // Full uses registered occupancy only, so a same-cycle pop never opens a
  // slot for a push and req_rdy has no path from the response side.
  assign w_full       = (r_pending == c_cnt_full);
  assign mul_req_val  = req_val & ~w_full;
  assign req_rdy      = mul_req_rdy & ~w_full;
  assign mul_req_msg  = req_msg;
  assign w_req_fire   = req_val & req_rdy;

  assign mul_resp_rdy = ~r_resp_val | resp_rdy;
  assign w_mul_fire   = mul_resp_val & mul_resp_rdy;
  assign w_pop        = w_mul_fire & (r_pending != c_cnt_zero);
  assign w_spurious   = w_mul_fire & (r_pending == c_cnt_zero);
  assign w_resp_fire  = r_resp_val & resp_rdy;

  assign resp_val = r_resp_val;
  assign resp_msg = r_resp_msg;
  assign resp_tag = r_resp_tag;
  assign pending  = r_pending;
  assign err      = r_err;

  // Tag storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_tags[r_wr_ptr] <= req_tag;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
    end else begin
      if (w_req_fire) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_req_fire, w_pop})
        2'b10:   r_pending <= r_pending + c_cnt_one;
        2'b01:   r_pending <= r_pending - c_cnt_one;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Output register: loads on a legal product, clears once drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_val <= 1'b0;
      r_resp_msg <= '0;
      r_resp_tag <= '0;
    end else if (w_pop) begin
      r_resp_val <= 1'b1;
      r_resp_msg <= mul_resp_msg;
      r_resp_tag <= r_tags[r_rd_ptr];
    end else if (w_resp_fire) begin
      r_resp_val <= 1'b0;
    end
  end

  // Sticky flag for a product arriving with no tag outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_tag_tracker.sv
// Bench for mul_tag_tracker: queue-based reference model plus an in-order
// multiplier model with configurable latency.
module tb_mul_tag_tracker;

  localparam int TW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_val;
  logic          req_rdy;
  logic [63:0]   req_msg;
  logic [TW-1:0] req_tag;
  logic          mul_req_val;
  logic          mul_req_rdy;
  logic [63:0]   mul_req_msg;
  logic          mul_resp_val;
  logic          mul_resp_rdy;
  logic [31:0]   mul_resp_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [31:0]   resp_msg;
  logic [TW-1:0] resp_tag;
  logic [1:0]    pending;
  logic          err;

  mul_tag_tracker #(.p_tag_nbits(TW), .p_depth(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_tag(req_tag),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg), .resp_tag(resp_tag),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  // stimulus controls
  logic          d_req_val = 0;
  logic [31:0]   d_a = 0, d_b = 0;
  logic [TW-1:0] d_tag = 0;
  logic          d_mul_req_rdy = 1, d_resp_rdy = 1;
  bit            mul_en = 1, spur = 0;
  int            fixed_lat = 1;

  // reference model
  logic [TW-1:0] tagq[$];
  bit            m_val = 0;
  logic [31:0]   m_msg = 0;
  logic [TW-1:0] m_tag = 0;
  bit            m_err = 0;

  typedef struct { logic [31:0] p; int rdy; } mop_t;
  mop_t mq[$];
  int   cyc = 0, last_rdy = 0;

  logic [TW-1:0] dlog_tag[$];
  logic [31:0]   dlog_msg[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    tagq.delete(); mq.delete();
    m_val = 0; m_msg = 0; m_tag = 0; m_err = 0; last_rdy = 0;
  endtask

  // One clock cycle: drive, compare everything against the model, advance model.
  task automatic step(output bit o_req_fire);
    bit e_full, e_req_rdy, e_mresp_rdy, rf, mf, of_, had;
    int lat, r;
    @(negedge clk);
    req_val = d_req_val; req_msg = {d_a, d_b}; req_tag = d_tag;
    mul_req_rdy = d_mul_req_rdy; resp_rdy = d_resp_rdy;
    if (spur) begin
      mul_resp_val = 1; mul_resp_msg = $urandom;
    end else if (mul_en && mq.size() > 0 && mq[0].rdy <= cyc) begin
      mul_resp_val = 1; mul_resp_msg = mq[0].p;
    end else begin
      mul_resp_val = 0; mul_resp_msg = $urandom;
    end
    #1;
    e_full      = (tagq.size() == DEPTH);
    e_req_rdy   = d_mul_req_rdy && !e_full;
    e_mresp_rdy = !m_val || d_resp_rdy;
    chk("resp_val", resp_val, m_val);
    chk("resp_msg", resp_msg, m_msg);
    chk("resp_tag", resp_tag, m_tag);
    chk("pending", pending, tagq.size());
    chk("err", err, m_err);
    chk("req_rdy", req_rdy, e_req_rdy);
    chk("mul_req_val", mul_req_val, d_req_val && !e_full);
    chk("mul_resp_rdy", mul_resp_rdy, e_mresp_rdy);
    chk("mul_req_msg", mul_req_msg, {d_a, d_b});
    rf  = d_req_val && e_req_rdy;
    mf  = mul_resp_val && e_mresp_rdy;
    of_ = m_val && d_resp_rdy;
    had = (tagq.size() > 0);
    if (of_) begin
      dlog_tag.push_back(resp_tag);
      dlog_msg.push_back(resp_msg);
    end
    @(posedge clk);
    cyc++;
    if (mf) begin
      if (had) begin
        m_tag = tagq.pop_front(); m_msg = mul_resp_msg; m_val = 1;
        if (!spur) void'(mq.pop_front());
      end else begin
        m_err = 1;
      end
    end else if (of_) begin
      m_val = 0;
    end
    if (rf) begin
      tagq.push_back(d_tag);
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      r = cyc + lat - 1;
      if (r < last_rdy) r = last_rdy;
      last_rdy = r;
      mq.push_back('{p: d_a * d_b, rdy: r});
    end
    o_req_fire = rf;
  endtask

  task automatic issue(input logic [TW-1:0] t, input logic [31:0] a, input logic [31:0] b, input bit rnd);
    bit f = 0;
    d_req_val = 1; d_tag = t; d_a = a; d_b = b;
    for (int k = 0; k < 60 && !f; k++) begin
      if (rnd) begin
        d_mul_req_rdy = 1'($urandom_range(0, 1));
        d_resp_rdy    = 1'($urandom_range(0, 1));
      end
      step(f);
    end
    chk("issue_accepted", f, 1);
    d_req_val = 0;
  endtask

  task automatic drain();
    bit f, done = 0;
    d_req_val = 0; d_resp_rdy = 1; mul_en = 1;
    for (int k = 0; k < 100 && !done; k++) begin
      step(f);
      done = (tagq.size() == 0) && !m_val;
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    reset_n = 0; req_val = 0; req_msg = 0; req_tag = 0; mul_req_rdy = 1;
    mul_resp_val = 0; mul_resp_msg = 0; resp_rdy = 1;
    #2;
    chk("rst_resp_val", resp_val, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err, 0);
    chk("rst_resp_msg", resp_msg, 0);
    @(negedge clk); reset_n = 1;

    // single op, 1-cycle multiplier
    fixed_lat = 1;
    d_req_val = 1; d_tag = 7; d_a = 3; d_b = 5;
    step(f);
    d_req_val = 0;
    #2;
    chk("single_no_early_val", resp_val, 0);
    chk("single_pending1", pending, 1);
    step(f);
    #2;
    chk("single_val", resp_val, 1);
    chk("single_msg", resp_msg, 15);
    chk("single_tag", resp_tag, 7);
    chk("single_pending0", pending, 0);
    drain();

    // fill with multiplier silent
    mul_en = 0; d_mul_req_rdy = 1;
    d_req_val = 1; d_a = 2; d_b = 9;
    d_tag = 10; step(f);
    d_tag = 11; step(f);
    d_tag = 12; step(f);
    #2;
    chk("fill_pending2", pending, 2);
    chk("fill_req_rdy0", req_rdy, 0);
    chk("fill_mul_req_val0", mul_req_val, 0);
    mul_en = 1;
    issue(12, 2, 9, 0);
    drain();

    // backpressure on writeback
    d_resp_rdy = 0;
    issue(20, 4, 5, 0);
    issue(21, 6, 7, 0);
    for (int k = 0; k < 3; k++) step(f);
    #2;
    chk("bp_val_held", resp_val, 1);
    chk("bp_tag_held", resp_tag, 20);
    chk("bp_msg_held", resp_msg, 20);
    chk("bp_mul_resp_rdy0", mul_resp_rdy, 0);
    chk("bp_pending1", pending, 1);
    dlog_tag.delete(); dlog_msg.delete();
    drain();
    chk("bp_count", dlog_tag.size(), 2);
    if (dlog_tag.size() == 2) begin
      chk("bp_tag0", dlog_tag[0], 20); chk("bp_msg0", dlog_msg[0], 20);
      chk("bp_tag1", dlog_tag[1], 21); chk("bp_msg1", dlog_msg[1], 42);
    end

    // wrap: 10 ops, random stalls and latency
    fixed_lat = 0;
    dlog_tag.delete(); dlog_msg.delete();
    for (int i = 0; i < 10; i++) issue(TW'(i), 32'(i + 1), 32'(i + 3), 1);
    d_mul_req_rdy = 1;
    drain();
    chk("wrap_count", dlog_tag.size(), 10);
    for (int i = 0; i < 10 && i < dlog_tag.size(); i++) begin
      chk("wrap_tag", dlog_tag[i], i);
      chk("wrap_msg", dlog_msg[i], (i + 1) * (i + 3));
    end
    chk("wrap_err0", err, 0);

    // spurious product
    fixed_lat = 1;
    spur = 1; step(f); spur = 0;
    #2;
    chk("spur_err", err, 1);
    chk("spur_resp_val", resp_val, 0);
    chk("spur_pending", pending, 0);
    step(f);

    // reset mid-operation
    d_resp_rdy = 0; mul_en = 1;
    issue(1, 2, 2, 0);
    step(f);
    mul_en = 0;
    issue(2, 3, 3, 0);
    issue(4, 5, 5, 0);
    #2;
    chk("mid_pending2", pending, 2);
    chk("mid_resp_val", resp_val, 1);
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    chk("arst_resp_val", resp_val, 0);
    chk("arst_resp_msg", resp_msg, 0);
    chk("arst_resp_tag", resp_tag, 0);
    chk("arst_pending", pending, 0);
    chk("arst_err", err, 0);
    model_reset();
    @(posedge clk); #2;
    reset_n = 1;
    mul_en = 1; d_resp_rdy = 1;
    dlog_tag.delete(); dlog_msg.delete();
    issue(3, 6, 7, 0);
    drain();
    chk("post_count", dlog_tag.size(), 1);
    if (dlog_tag.size() > 0) begin
      chk("post_tag", dlog_tag[0], 3);
      chk("post_msg", dlog_msg[0], 42);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
